alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle.sv | 164 ++++++++++++++++
 tb/tb_alu_multicycle.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
`timescale 1ns/1ps
// Accumulator ALU on a shared tri-state system bus. Single-cycle logic/arith ops,
// plus an unsigned shift-add multiply that takes WORD_W busy cycles.
module alu_multicycle #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 3
) (
    input  logic              clock,
    input  logic              reset,
    inout  wire  [WORD_W-1:0] sysbus,
    input  logic              ACC_bus,
    input  logic              load_ACC,
    input  logic              ALU_ACC,
    input  logic [OP_W-1:0]   ALU_op,
    output logic              busy,
    output logic              done,
    output logic              z_flag,
    output logic              n_flag,
    output logic              c_flag,
    output logic              v_flag
);
    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    localparam int MSB = WORD_W - 1;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t              state_reg, state_next;
    logic [WORD_W-1:0]   acc_reg, acc_next;
    logic                c_reg, c_next;
    logic                v_reg, v_next;
    logic                done_reg, done_next;
    logic [2*WORD_W-1:0] mcand_reg, mcand_next;
    logic [WORD_W-1:0]   mplier_reg, mplier_next;
    logic [2*WORD_W-1:0] product_reg, product_next;
    logic [CNT_W-1:0]    count_reg, count_next;

    logic [2:0]          op3;
    logic [WORD_W:0]     sum_ext;
    logic [WORD_W:0]     diff_ext;
    logic [2*WORD_W-1:0] product_sum;

    // Only the three low op-code bits carry meaning.
    assign op3         = 3'(ALU_op);
    assign sum_ext     = {1'b0, acc_reg} + {1'b0, sysbus};
    assign diff_ext    = {1'b0, acc_reg} - {1'b0, sysbus};
    assign product_sum = product_reg + (mplier_reg[0] ? mcand_reg : '0);

    assign sysbus = ACC_bus ? acc_reg : {WORD_W{1'bz}};

    assign z_flag = (acc_reg == '0);
    assign n_flag = acc_reg[MSB];
    assign c_flag = c_reg;
    assign v_flag = v_reg;
    assign busy   = (state_reg == ST_MUL);
    assign done   = done_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            acc_reg     <= '0;
            c_reg       <= 1'b0;
            v_reg       <= 1'b0;
            done_reg    <= 1'b0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            product_reg <= '0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            c_reg       <= c_next;
            v_reg       <= v_next;
            done_reg    <= done_next;
            mcand_reg   <= mcand_next;
            mplier_reg  <= mplier_next;
            product_reg <= product_next;
            count_reg   <= count_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        c_next       = c_reg;
        v_next       = v_reg;
        done_next    = 1'b0;
        mcand_next   = mcand_reg;
        mplier_next  = mplier_reg;
        product_next = product_reg;
        count_next   = count_reg;

        case (state_reg)
            ST_IDLE: begin
                if (load_ACC) begin
                    if (!ALU_ACC) begin
                        acc_next = sysbus;
                    end else begin
                        case (op3)
                            3'b000: begin
                                acc_next = sum_ext[WORD_W-1:0];
                                c_next   = sum_ext[WORD_W];
                                v_next   = (acc_reg[MSB] == sysbus[MSB]) &&
                                           (sum_ext[MSB] != acc_reg[MSB]);
                            end
                            3'b001: begin
                                acc_next = diff_ext[WORD_W-1:0];
                                c_next   = diff_ext[WORD_W];
                                v_next   = (acc_reg[MSB] != sysbus[MSB]) &&
                                           (diff_ext[MSB] != acc_reg[MSB]);
                            end
                            3'b010: begin
                                acc_next = acc_reg ^ sysbus;
                                c_next   = 1'b0;
                                v_next   = 1'b0;
                            end
                            3'b011: begin
                                acc_next = acc_reg & sysbus;
                                c_next   = 1'b0;
                                v_next   = 1'b0;
                            end
                            3'b100: begin
                                acc_next = acc_reg | sysbus;
                                c_next   = 1'b0;
                                v_next   = 1'b0;
                            end
                            3'b101: begin
                                acc_next = acc_reg << 1;
                                c_next   = acc_reg[MSB];
                                v_next   = 1'b0;
                            end
                            3'b110: begin
                                acc_next = acc_reg >> 1;
                                c_next   = acc_reg[0];
                                v_next   = 1'b0;
                            end
                            default: begin
                                // Latch both operands; the bus is free for other users while busy.
                                mcand_next   = {{WORD_W{1'b0}}, acc_reg};
                                mplier_next  = sysbus;
                                product_next = '0;
                                count_next   = '0;
                                state_next   = ST_MUL;
                            end
                        endcase
                    end
                end
            end
            default: begin
                product_next = product_sum;
                mcand_next   = mcand_reg << 1;
                mplier_next  = mplier_reg >> 1;
                count_next   = count_reg + CNT_W'(1);
                if (count_reg == LAST_BIT) begin
                    acc_next   = product_sum[WORD_W-1:0];
                    c_next     = (product_sum[2*WORD_W-1:WORD_W] != '0);
                    v_next     = 1'b0;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_alu_multicycle.sv
`timescale 1ns/1ps
// Directed bench for alu_multicycle: a per-cycle reference model plus literal checks.
module tb_alu_multicycle;
    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         ACC_bus;
    logic         load_ACC;
    logic         ALU_ACC;
    logic [2:0]   ALU_op;
    logic         busy, done, z_flag, n_flag, c_flag, v_flag;
    logic         tb_en;
    logic [W-1:0] tb_drv;
    wire  [W-1:0] sysbus;

    assign sysbus = tb_en ? tb_drv : {W{1'bz}};

    always #5 clock = ~clock;

    alu_multicycle #(.WORD_W(W), .OP_W(3)) dut (
        .clock(clock), .reset(reset), .sysbus(sysbus), .ACC_bus(ACC_bus),
        .load_ACC(load_ACC), .ALU_ACC(ALU_ACC), .ALU_op(ALU_op),
        .busy(busy), .done(done), .z_flag(z_flag), .n_flag(n_flag),
        .c_flag(c_flag), .v_flag(v_flag)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic cmp(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h, expected %02h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: arithmetic on integers, multiply as a plain product
    // that lands after W busy cycles.
    int unsigned m_acc, m_prod, m_left;
    bit m_c, m_v, m_busy, m_done, m_valid = 0;

    always @(posedge clock) begin
        int unsigned a, b;
        int sa, sb, sr;
        if (reset) begin
            m_acc = 0; m_c = 0; m_v = 0; m_busy = 0; m_done = 0; m_left = 0; m_prod = 0;
            m_valid = 1;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_acc  = m_prod % 256;
                    m_c    = (m_prod / 256) != 0;
                    m_v    = 0;
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (load_ACC) begin
                a  = m_acc;
                b  = int'(sysbus);
                sa = (a > 127) ? int'(a) - 256 : int'(a);
                sb = (b > 127) ? int'(b) - 256 : int'(b);
                if (!ALU_ACC) m_acc = b;
                else case (ALU_op)
                    3'd0: begin
                        m_c = (a + b) > 255; sr = sa + sb;
                        m_v = (sr > 127) || (sr < -128); m_acc = (a + b) % 256;
                    end
                    3'd1: begin
                        m_c = a < b; sr = sa - sb;
                        m_v = (sr > 127) || (sr < -128); m_acc = (a + 256 - b) % 256;
                    end
                    3'd2: begin m_acc = a ^ b; m_c = 0; m_v = 0; end
                    3'd3: begin m_acc = a & b; m_c = 0; m_v = 0; end
                    3'd4: begin m_acc = a | b; m_c = 0; m_v = 0; end
                    3'd5: begin m_c = a >= 128; m_acc = (a * 2) % 256; m_v = 0; end
                    3'd6: begin m_c = (a % 2) == 1; m_acc = a / 2; m_v = 0; end
                    default: begin m_prod = a * b; m_busy = 1; m_left = W; end
                endcase
            end
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            cmp("z_flag", {7'd0, z_flag}, {7'd0, m_acc == 0});
            cmp("n_flag", {7'd0, n_flag}, {7'd0, m_acc >= 128});
            cmp("c_flag", {7'd0, c_flag}, {7'd0, m_c});
            cmp("v_flag", {7'd0, v_flag}, {7'd0, m_v});
            cmp("busy",   {7'd0, busy},   {7'd0, m_busy});
            cmp("done",   {7'd0, done},   {7'd0, m_done});
            if (ACC_bus && !tb_en) cmp("bus_acc", sysbus, m_acc[W-1:0]);
        end
    end

    task automatic op(input logic alu, input logic [2:0] code, input logic [W-1:0] val);
        $display("txn load alu=%0d op=%0d bus=%02h", alu, code, val);
        load_ACC = 1; ALU_ACC = alu; ALU_op = code;
        ACC_bus = 0; tb_en = 1; tb_drv = val;
        @(posedge clock); #1;
        load_ACC = 0; ALU_ACC = 0; tb_en = 0; ACC_bus = 1;
        @(negedge clock);
    endtask

    // Counts busy cycles; returns at the negedge of the first non-busy cycle.
    task automatic wait_mul(output int nb);
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy) break;
            nb++;
            @(negedge clock);
        end
        if (busy) begin
            vectors++; miscompares++;
            $display("FAIL mul_timeout: busy still %0d after 20 cycles", busy);
        end
    endtask

    initial begin
        int nb, pulses;
        reset = 1; ACC_bus = 0; load_ACC = 0; ALU_ACC = 0; ALU_op = 0; tb_en = 0; tb_drv = 0;
        repeat (2) @(posedge clock);
        #1;
        cmp("reset_z", {7'd0, z_flag}, 8'd1);
        cmp("reset_busy", {7'd0, busy}, 8'd0);
        reset = 0; ACC_bus = 1;
        @(negedge clock);

        op(0, 0, 8'hF0); op(1, 0, 8'h20);
        cmp("add_acc", sysbus, 8'h10); cmp("add_c", {7'd0, c_flag}, 8'd1);
        cmp("add_v", {7'd0, v_flag}, 8'd0);
        op(0, 0, 8'h7F); op(1, 0, 8'h01);
        cmp("addv_acc", sysbus, 8'h80); cmp("addv_v", {7'd0, v_flag}, 8'd1);
        cmp("addv_n", {7'd0, n_flag}, 8'd1); cmp("addv_c", {7'd0, c_flag}, 8'd0);

        op(0, 0, 8'h05); op(1, 1, 8'h05);
        cmp("sub0_acc", sysbus, 8'h00); cmp("sub0_z", {7'd0, z_flag}, 8'd1);
        cmp("sub0_c", {7'd0, c_flag}, 8'd0);
        op(0, 0, 8'h03); op(1, 1, 8'h05);
        cmp("subb_acc", sysbus, 8'hFE); cmp("subb_c", {7'd0, c_flag}, 8'd1);
        cmp("subb_n", {7'd0, n_flag}, 8'd1);

        op(0, 0, 8'hF0); op(1, 2, 8'hFF); cmp("xor_acc", sysbus, 8'h0F);
        op(1, 3, 8'h3C); cmp("and_acc", sysbus, 8'h0C);
        op(1, 4, 8'h80); cmp("or_acc", sysbus, 8'h8C); cmp("or_c", {7'd0, c_flag}, 8'd0);

        op(0, 0, 8'h81); op(1, 5, 8'hFF);
        cmp("shl_acc", sysbus, 8'h02); cmp("shl_c", {7'd0, c_flag}, 8'd1);
        op(0, 0, 8'h81); op(1, 6, 8'h00);
        cmp("shr_acc", sysbus, 8'h40); cmp("shr_c", {7'd0, c_flag}, 8'd1);
        op(0, 0, 8'h00); cmp("load_keeps_c", {7'd0, c_flag}, 8'd1);
        repeat (3) @(negedge clock);
        cmp("hold_acc", sysbus, 8'h00);

        op(0, 0, 8'h12); op(1, 7, 8'h0D);
        cmp("mul_orig_on_bus", sysbus, 8'h12);
        wait_mul(nb);
        cmp("mul_busy_cycles", 8'(nb), 8'd8);
        cmp("mul_done", {7'd0, done}, 8'd1); cmp("mul_acc", sysbus, 8'hEA);
        cmp("mul_c", {7'd0, c_flag}, 8'd0);
        op(1, 7, 8'h02);
        wait_mul(nb);
        cmp("b2b_cycles", 8'(nb), 8'd8); cmp("b2b_acc", sysbus, 8'hD4);
        cmp("b2b_c", {7'd0, c_flag}, 8'd1);

        op(0, 0, 8'h10); op(1, 7, 8'h10);
        wait_mul(nb);
        cmp("mul16_acc", sysbus, 8'h00); cmp("mul16_z", {7'd0, z_flag}, 8'd1);
        cmp("mul16_c", {7'd0, c_flag}, 8'd1);

        op(0, 0, 8'h03); op(1, 7, 8'h05);
        @(negedge clock);
        $display("txn lockout load bus=55 while busy");
        load_ACC = 1; ALU_ACC = 0; ACC_bus = 0; tb_en = 1; tb_drv = 8'h55;
        @(posedge clock); #1;
        load_ACC = 0; tb_en = 0; ACC_bus = 1;
        @(negedge clock);
        wait_mul(nb);
        cmp("lockout_acc", sysbus, 8'h0F); cmp("lockout_done", {7'd0, done}, 8'd1);

        op(0, 0, 8'h07); op(1, 7, 8'h09);
        repeat (3) @(negedge clock);
        $display("txn reset during busy");
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        @(negedge clock);
        cmp("abort_busy", {7'd0, busy}, 8'd0); cmp("abort_acc", sysbus, 8'h00);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) pulses++;
            @(negedge clock);
        end
        cmp("abort_no_done", 8'(pulses), 8'd0);
        op(0, 0, 8'h3C); cmp("after_abort_load", sysbus, 8'h3C);

        ACC_bus = 0; tb_en = 1; tb_drv = 8'hA5;
        @(negedge clock);
        cmp("bus_released", sysbus, 8'hA5);
        tb_en = 0; ACC_bus = 1;
        @(negedge clock);
        cmp("bus_driven", sysbus, 8'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
